addr_gen: RTL and testbench

ADDR_GEN -- requirements
Module: addr_gen

---
 rtl/addr_gen.sv | 83 ++++++++
 tb/tb_addr_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/addr_gen.sv
// Address generator for a pipelined NTT/INVNTT/MULT/ADDSUB datapath.
// Produces twiddle ROM address, coefficient read address and a delayed write-back address.
module addr_gen (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode,
   input  logic [7:0] clk_counter,
   output logic [6:0] coef_addr,
   output logic [4:0] r_addr,
   output logic [4:0] w_addr
);

   localparam int unsigned CW    = 7;
   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 4;

   localparam logic [1:0] MODE_NTT    = 2'd0;
   localparam logic [1:0] MODE_INVNTT = 2'd1;
   localparam logic [1:0] MODE_MULT   = 2'd2;
   localparam logic [1:0] MODE_ADDSUB = 2'd3;

   localparam logic [2:0] STAGE_LAST = 3'd6;
   localparam logic [2:0] STAGE_IDLE = 3'd7;

   logic [2:0]    stage;
   logic [AW-1:0] j;
   logic [CW-1:0] coef_c;
   logic [CW-1:0] two_j_c;
   logic [AW-1:0] pipe [DEPTH-1];

   assign stage   = clk_counter[7:5];
   assign j       = clk_counter[4:0];
   assign two_j_c = CW'({j, 1'b0});

   // Twiddle address per mode and stage
   always_comb begin
      coef_c = '0;
      unique case (mode)
         MODE_NTT: begin
            if (stage == STAGE_IDLE)
               coef_c = '0;
            else if (stage == STAGE_LAST)
               coef_c = 7'd64 + two_j_c;
            else
               coef_c = CW'(7'd1 << stage) + (CW'(j) >> (3'd5 - stage));
         end
         MODE_INVNTT: begin
            if (stage == STAGE_IDLE)
               coef_c = '0;
            else if (stage == 3'd0)
               coef_c = 7'd127 - two_j_c;
            else
               coef_c = CW'((8'd128 >> stage) - 8'd1) - (CW'(j) >> (stage - 3'd1));
         end
         MODE_MULT:   coef_c = 7'd64 + two_j_c;
         MODE_ADDSUB: coef_c = '0;
         default:     coef_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coef_addr <= '0;
         r_addr    <= '0;
      end else begin
         coef_addr <= coef_c;
         r_addr    <= j;
      end
   end

   // Write-back address trails the read address by the butterfly pipeline depth
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH) - 1; i++) pipe[i] <= '0;
         w_addr <= '0;
      end else begin
         pipe[0] <= r_addr;
         for (int i = 1; i < int'(DEPTH) - 1; i++) pipe[i] <= pipe[i-1];
         w_addr <= pipe[DEPTH-2];
      end
   end

endmodule

// File: tb/tb_addr_gen.sv
// Scoreboard bench for addr_gen: directed vectors per mode/stage, a full NTT sweep,
// and asynchronous reset behaviour including a mid-sweep reset.
module tb_addr_gen;

   logic       clk;
   logic       rst;
   logic [1:0] mode;
   logic [7:0] clk_counter;
   logic [6:0] coef_addr;
   logic [4:0] r_addr;
   logic [4:0] w_addr;

   addr_gen dut (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .clk_counter (clk_counter),
      .coef_addr   (coef_addr),
      .r_addr      (r_addr),
      .w_addr      (w_addr)
   );

   typedef struct {
      bit         chk_coef;
      logic [6:0] coef;
      logic [4:0] r;
      logic [4:0] w;
      int         tag;
   } exp_t;

   exp_t       sb [$];
   logic [4:0] hist [$];
   int         n_cmp  = 0;
   int         n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int tag, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s tag=%0d got=%0d expected=%0d", name, tag, act, exp);
      end
   endtask

   task automatic clear_hist();
      hist.delete();
      repeat (4) hist.push_back(5'd0);
   endtask

   // One clock of stimulus; pushes the outputs expected after the following rising edge
   task automatic step(input logic rv, input logic [1:0] m, input logic [7:0] cnt,
                       input bit chk, input logic [6:0] c, input int tag);
      exp_t e;
      @(negedge clk);
      rst         = rv;
      mode        = m;
      clk_counter = cnt;
      e.tag       = tag;
      if (!rv) begin
         clear_hist();
         e.chk_coef = 1'b1;
         e.coef     = 7'd0;
         e.r        = 5'd0;
         e.w        = 5'd0;
         sb.push_back(e);
         #1;
         check("async_coef", tag, int'(coef_addr), 0);
         check("async_r",    tag, int'(r_addr),    0);
         check("async_w",    tag, int'(w_addr),    0);
      end else begin
         e.chk_coef = chk;
         e.coef     = c;
         e.r        = cnt[4:0];
         e.w        = hist.pop_front();
         hist.push_back(e.r);
         sb.push_back(e);
      end
   endtask

   // Monitor: outputs are presented every cycle, compare just after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_coef) check("coef_addr", e.tag, int'(coef_addr), int'(e.coef));
            check("r_addr", e.tag, int'(r_addr), int'(e.r));
            check("w_addr", e.tag, int'(w_addr), int'(e.w));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog tag=0 got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   localparam int NV = 22;
   logic [1:0] v_mode [NV] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                               2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                               2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
   logic [7:0] v_cnt  [NV] = '{8'h00, 8'h23, 8'h74, 8'hB1, 8'hDF, 8'hE4, 8'h1F, 8'h48, 8'h9F,
                               8'h05, 8'h49, 8'hCC, 8'h3F, 8'h6F, 8'hBF, 8'hE0, 8'h00,
                               8'h07, 8'hA0, 8'hFF, 8'hDF, 8'h05};
   logic [6:0] v_coef [NV] = '{7'd1, 7'd2, 7'd13, 7'd49, 7'd126, 7'd0, 7'd1, 7'd5, 7'd31,
                               7'd117, 7'd27, 7'd1, 7'd32, 7'd12, 7'd2, 7'd0, 7'd127,
                               7'd78, 7'd64, 7'd126, 7'd0, 7'd0};

   initial begin
      int waited;
      clear_hist();
      rst         = 1'b0;
      mode        = 2'd2;
      clk_counter = 8'hAB;
      #1;
      check("por_coef", 0, int'(coef_addr), 0);
      check("por_r",    0, int'(r_addr),    0);
      check("por_w",    0, int'(w_addr),    0);
      step(1'b0, 2'd1, 8'h3F, 1'b1, 7'd0, 1);
      step(1'b0, 2'd0, 8'h55, 1'b1, 7'd0, 2);

      // Directed vectors; modes change cycle to cycle without flushing w_addr
      for (int i = 0; i < NV; i++)
         step(1'b1, v_mode[i], v_cnt[i], 1'b1, v_coef[i], 100 + i);

      // NTT sweep with a reset pulse at counter 100
      for (int c = 0; c < 224; c++) begin
         if (c == 100) begin
            step(1'b0, 2'd0, 8'(c), 1'b1, 7'd0, 1000 + c);
            step(1'b0, 2'd0, 8'(c), 1'b1, 7'd0, 1000 + c);
         end
         step(1'b1, 2'd0, 8'(c), 1'b0, 7'd0, 1000 + c);
      end

      // Trailing idle cycles drain the write-back pipeline
      for (int i = 0; i < 6; i++)
         step(1'b1, 2'd3, 8'(8'hE0 + i), 1'b1, 7'd0, 2000 + i);

      waited = 0;
      while (sb.size() > 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (sb.size() > 0) check("drain", 0, sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
